// File: rtl/inv_shift_sub_unit.sv
// inv_shift_sub_unit: AES InvShiftRows followed by InvSubBytes on a 128-bit state,
// producing one output column per cycle through four inverse S-box lanes.
module inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] inv_table = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };
   assign y = inv_table[a];
endmodule

module inv_shift_sub_unit (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [1:0] col;
   logic [127:0] buffer;
   logic [3:0][31:0] result;
   logic [7:0] buf_b [16];
   logic [7:0] lane_in [4];
   logic [7:0] lane_out [4];
   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign buf_b[i] = buffer[127-8*i -: 8];
   end
   // Lane r fetches row r of source column (col - r) mod 4, i.e. byte {src_col, r}.
   for (genvar r = 0; r < 4; r++) begin : g_lane
      logic [1:0] src_col;
      assign src_col = col - 2'(r);
      assign lane_in[r] = buf_b[{src_col, 2'(r)}];
      inv_sbox u_sbox (.a(lane_in[r]), .y(lane_out[r]));
   end
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? BUSY : IDLE;
         BUSY:    state_nx = (col == 2'd3) ? DONE : BUSY;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end
   // Column c lives in result[3-c] so that column 0 occupies the top 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= 2'd0;
         buffer <= '0;
         result <= '0;
      end else if (state == IDLE && in_valid) begin
         buffer <= state_in;
         col <= 2'd0;
      end else if (state == BUSY) begin
         result[~col] <= {lane_out[0], lane_out[1], lane_out[2], lane_out[3]};
         col <= col + 2'd1;
      end
   end
   assign in_ready = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_out = result;
endmodule
